// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM states,
// parameter defaults and legal parameter ranges.
package uart_pkg;

    localparam int DATA_BITS_DEF    = 6;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int STOP_BITS_DEF    = 1;

    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;
    localparam int CLKS_PER_BIT_MIN = 4;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Mid-bit sample timer: load_half arms a half-bit delay (start-bit centre),
// load_full a whole bit period; sample_tick fires when the count expires.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic load_half,
    input  logic load_full,
    output logic sample_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_half) begin
            cnt_d = HALF_LD;
        end else if (load_full) begin
            cnt_d = FULL_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_tick = run && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with valid/ready output and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = STOP_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] bits_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS outside legal range");
    end
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
        $error("uart_rx_param: CLKS_PER_BIT below minimum");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           rst_sync_q, rst_sync_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 frame_bad_q, frame_bad_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] bits_out_q, bits_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;

    logic rx_s;
    logic rx_en;
    logic tick;
    logic load_half;
    logic load_full;
    logic deliver;
    logic deliver_ferr;
    logic accept;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    assign rx_s  = sync_q[1];
    assign rx_en = rst_sync_q[1];

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_q != ST_IDLE),
        .load_half  (load_half),
        .load_full  (load_full),
        .sample_tick(tick)
    );

    always_comb begin
        sync_d       = {sync_q[0], serial_in};
        rst_sync_d   = {rst_sync_q[0], 1'b1};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        frame_bad_d  = frame_bad_q;
        shift_d      = shift_q;
        load_half    = 1'b0;
        load_full    = 1'b0;
        deliver      = 1'b0;
        deliver_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_en && !rx_s) begin
                    state_d   = ST_START;
                    load_half = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DATA;
                        load_full   = 1'b1;
                        bit_cnt_d   = '0;
                        stop_cnt_d  = 1'b0;
                        frame_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d   = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    load_full = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d = ^{shift_q, rx_s};
                    state_d   = ST_STOP;
                    load_full = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    // The word is released on the edge after the last stop sample.
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d      = ST_IDLE;
                        deliver      = 1'b1;
                        deliver_ferr = frame_bad_q | ~rx_s;
                    end else begin
                        stop_cnt_d  = stop_cnt_q + 1'b1;
                        frame_bad_d = frame_bad_q | ~rx_s;
                        load_full   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ce) begin
            state_d      = ST_IDLE;
            load_half    = 1'b0;
            load_full    = 1'b0;
            deliver      = 1'b0;
            deliver_ferr = 1'b0;
        end
    end

    always_comb begin
        accept        = rx_valid_q & rx_ready;
        bits_out_d    = deliver ? shift_q : bits_out_q;
        rx_valid_d    = deliver | (rx_valid_q & ~rx_ready);
        // Simultaneous accept and completion frees the slot, so no overrun.
        overrun_err_d = (overrun_err_q & ~accept) | (deliver & rx_valid_q & ~rx_ready);
        frame_err_d   = (frame_err_q & ~accept) | deliver_ferr;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = (parity_err_q & ~accept) | (deliver & par_bad_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sync_q        <= 2'b11;
            rst_sync_q    <= 2'b00;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            bits_out_q    <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            rst_sync_q    <= rst_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            frame_bad_q   <= frame_bad_d;
            bits_out_q    <= bits_out_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign bits_out    = bits_out_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 6, data bits per frame, legal range 5..9, LSB first.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per bit period, minimum 4.
REQ-003 Parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-004 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port ce, input, 1, active-low chip enable; high aborts any frame and forces IDLE.
REQ-007 Port serial_in, input, 1, asynchronous serial line, idle high.
REQ-008 Port bits_out, output, DATA_BITS, last received data word.
REQ-009 Port rx_valid, output, 1, bits_out holds an unconsumed word.
REQ-010 Port rx_ready, input, 1, consumer accepts the word when rx_valid and rx_ready are both high.
REQ-011 Port frame_err, output, 1, sticky: stop bit sampled low; cleared on acceptance.
REQ-012 Port overrun_err, output, 1, sticky: a word completed while rx_valid was high; cleared on acceptance.
REQ-013 Port parity_err, output, 1, sticky: parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-014 serial_in passes through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; encoding is free.
REQ-016 IDLE->START on the first synchronised low while ce is low; the bit counter loads CLKS_PER_BIT/2-1.
REQ-017 START samples at mid-bit: high returns to IDLE with no flags set (glitch reject); low goes to DATA.
REQ-018 DATA samples each bit once every CLKS_PER_BIT cycles at mid-bit, shifts LSB-first, and leaves after DATA_BITS samples.
REQ-019 STOP samples STOP_BITS bits: any low sample sets frame_err; the data word is still delivered.
REQ-020 The word is delivered at the cycle after the final stop sample: bits_out updates and rx_valid rises; latency from the start-bit falling edge is at most (1.5+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT+3 clk, where P=1 with parity and 0 without.
REQ-021 rx_valid stays high until a cycle with rx_ready high; rx_valid then drops on the next edge.
REQ-022 If a word completes while rx_valid is high, bits_out is overwritten with the new word, overrun_err is set and rx_valid stays high.
REQ-023 If acceptance and completion occur in the same cycle, the new word loads, rx_valid stays high and overrun_err is not set.
REQ-024 After STOP the FSM returns to IDLE, which allows back-to-back frames with no idle gap.
REQ-025 ce high mid-frame discards the partial word and returns to IDLE in 1 cycle; bits_out, rx_valid and the error flags hold.

Reset
REQ-026 rst_n low asynchronously forces IDLE, sets bits_out to 0, clears rx_valid and all error flags, and sets the synchroniser flops to 1.
REQ-027 Reset deassertion is synchronised internally; the first frame is accepted 2 cycles after release.

Configuration
REQ-028 With `UART_RX_PARITY_EN` defined, the PARITY state samples one bit after DATA; even parity mismatch sets parity_err; port parity_err exists.
REQ-029 Without `UART_RX_PARITY_EN`, DATA goes directly to STOP and port parity_err is absent.

Structure
REQ-030 Shared package uart_pkg holds the FSM state typedef, the parameter defaults and the legal-range constants.
REQ-031 Sub-module uart_bit_timer holds the mid-bit counter; it takes load_half/load_full inputs and produces a sample_tick output.
REQ-032 Illegal parameter values shall fail elaboration.

Verification
REQ-033 Defaults, frame 0x2D at 16 clk/bit -> bits_out=6'h2D, one rx_valid assertion, no error flags.
REQ-034 Low pulse of 5 clk on an idle line -> no rx_valid, FSM back in IDLE.
REQ-035 Frame 0x15 with stop bit driven low -> bits_out=6'h15, rx_valid=1, frame_err=1.
REQ-036 Two back-to-back frames 0x01 then 0x3F with rx_ready=0 -> bits_out=6'h3F, overrun_err=1; with rx_ready pulsed at the second completion -> overrun_err=0.
REQ-037 ce raised at data bit 3 -> no rx_valid; the next full frame 0x0A is received correctly.
REQ-038 Parity enabled, DATA_BITS=8, frame 0xA5 with odd parity bit -> parity_err=1; reset mid-frame -> all outputs 0 immediately.
